transpose_stream_ctrl: RTL

//  Streaming wrapper that sequences a full-matrix transpose. Accepts an MxN matrix one row per

---
 rtl/transpose_pkg.sv | 25 ++
 rtl/transpose_stream_ctrl_if.sv | 42 ++++
 rtl/transpose_col_mux.sv | 32 +++
 rtl/transpose_stream_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming matrix transpose controller.
package transpose_pkg;

   // Default geometry of the block.
   localparam int unsigned DEF_M          = 16;
   localparam int unsigned DEF_N          = 16;
   localparam int unsigned DEF_DATA_WIDTH = 8;

   // Two-phase operation: fill the buffer, then empty it column by column.
   typedef enum logic {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Counter width for a modulus of v; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   // LSB position of element idx inside a packed row of w-bit elements.
   function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/transpose_stream_ctrl_if.sv
// Row-serial input and output streams of the transpose controller.
// TRANSPOSE_LAST_CHECK_EN adds the in_last framing bit to the input stream.
interface transpose_stream_ctrl_if #(
   parameter int unsigned M          = 16,
   parameter int unsigned N          = 16,
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [N*DATA_WIDTH-1:0] in_row;
`ifdef TRANSPOSE_LAST_CHECK_EN
   logic                    in_last;
`endif
   logic                    out_valid;
   logic                    out_ready;
   logic [M*DATA_WIDTH-1:0] out_row;
   logic                    out_last;

   // Environment side: produces input rows, consumes output rows.
   modport master (
      output in_valid, in_row,
`ifdef TRANSPOSE_LAST_CHECK_EN
      output in_last,
`endif
      input  in_ready,
      input  out_valid, out_row, out_last,
      output out_ready
   );

   // Controller side.
   modport slave (
      input  in_valid, in_row,
`ifdef TRANSPOSE_LAST_CHECK_EN
      input  in_last,
`endif
      output in_ready,
      output out_valid, out_row, out_last,
      input  out_ready
   );

endinterface

// File: rtl/transpose_col_mux.sv
// Selects column col of the row buffer and packs it as one output row.
module transpose_col_mux
   import transpose_pkg::*;
#(
   parameter int unsigned M          = DEF_M,
   parameter int unsigned N          = DEF_N,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [M-1:0][N*DATA_WIDTH-1:0] rows,
   input  logic [clog2_min1(N)-1:0]       col,
   output logic [M*DATA_WIDTH-1:0]        out_row
);

   localparam int unsigned CW = clog2_min1(N);

   for (genvar i = 0; i < M; i++) begin : g_row
      logic [DATA_WIDTH-1:0] elem;

      // Element i of the output row is A[i][col].
      always_comb begin
         elem = '0;
         for (int unsigned j = 0; j < N; j++) begin
            if (col == CW'(j)) begin
               elem = rows[i][elem_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
            end
         end
      end

      assign out_row[i*DATA_WIDTH +: DATA_WIDTH] = elem;
   end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Streaming full-matrix transpose: load M rows of N elements, then emit the
// N columns as rows of M elements. Load and drain never overlap.
// Optional macro TRANSPOSE_LAST_CHECK_EN adds in_last framing check and sticky err.
module transpose_stream_ctrl
   import transpose_pkg::*;
#(
   parameter int unsigned M          = DEF_M,
   parameter int unsigned N          = DEF_N,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   transpose_stream_ctrl_if.slave bus,
`ifdef TRANSPOSE_LAST_CHECK_EN
   output logic                  err,
`endif
   output logic                  busy
);

   localparam int unsigned RW = clog2_min1(M);
   localparam int unsigned CW = clog2_min1(N);
   localparam int unsigned RL = N*DATA_WIDTH;

   state_e                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [M-1:0][RL-1:0]  row_buf_q;
   logic                  in_ready;
   logic                  out_valid;
   logic                  in_hs;
   logic                  out_hs;
   logic                  ld_en;
   logic                  row_at_last;
   logic                  col_at_last;

   assign row_at_last = (row_q == RW'(M-1));
   assign col_at_last = (col_q == CW'(N-1));

   // Ready/valid are pure decodes of registered state; clr masks acceptance.
   assign in_ready  = (state_q == LOAD) & ~clr;
   assign out_valid = (state_q == DRAIN);
   assign in_hs     = bus.in_valid & in_ready;
   assign out_hs    = out_valid & bus.out_ready & ~clr;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_valid & col_at_last;
   assign busy          = (state_q != LOAD) | (row_q != '0);

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Next-state and counter update; clr overrides any handshake.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      ld_en   = 1'b0;
      if (clr) begin
         state_d = LOAD;
         row_d   = '0;
         col_d   = '0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (in_hs) begin
                  ld_en = 1'b1;
                  if (row_at_last) begin
                     row_d   = '0;
                     col_d   = '0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (col_at_last) begin
                     col_d   = '0;
                     state_d = LOAD;
                  end else begin
                     col_d = col_q + CW'(1);
                  end
               end
            end
            default: state_d = LOAD;
         endcase
      end
   end

   // Row buffer: captures the accepted input row at slot row_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_buf_q <= '0;
      end else begin
         for (int unsigned r = 0; r < M; r++) begin
            if (ld_en && (row_q == RW'(r))) begin
               row_buf_q[r] <= bus.in_row;
            end
         end
      end
   end

   transpose_col_mux #(
      .M          (M),
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_col_mux (
      .rows    (row_buf_q),
      .col     (col_q),
      .out_row (bus.out_row)
   );

`ifdef TRANSPOSE_LAST_CHECK_EN
   // Sticky framing error: in_last must mark exactly the final input row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (clr) begin
         err <= 1'b0;
      end else if (in_hs && (bus.in_last != row_at_last)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
